// File: rtl/l2cache_pkg.sv
// Shared L2-side types: packed L1-to-L2 request layout and arbiter channel sizing.
// The request concentrator built on these types has an optional channel-0 priority mode (L1TOL2_ARB_PRIO_EN).
package l2cache_pkg;

    localparam int L1TOL2_ARB_NCH = 3;

    function automatic int chid_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    localparam int CHW = chid_width(L1TOL2_ARB_NCH);

    typedef logic [CHW-1:0] L1_chid_type;

    // One request beat as seen by the L2 pipe; its width is the concentrator payload width.
    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  size;
        logic [7:0]  byte_en;
        logic [47:0] addr;
        logic [63:0] wdata;
    } l1tol2_req_t;

    localparam int L1TOL2_REQ_W = $bits(l1tol2_req_t);

endpackage

// File: rtl/l1tol2_arb_fifo.sv
// Per-channel request FIFO with a registered full flag and a combinational head.
// The head is read without a register so an accepted request can be granted on the very next cycle.
module l1tol2_arb_fifo
    import l2cache_pkg::*;
#(
    parameter int DATA_W     = L1TOL2_REQ_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     count_next;
    logic              full_reg;

    always_comb begin
        count_next = count_reg + CW'(push) - CW'(pop);
    end

    // Full is registered from the next count, so a pop only frees the slot on the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            full_reg  <= (count_next == CW'(FIFO_DEPTH));
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign empty     = (count_reg == '0);
    assign full      = full_reg;

endmodule

// File: rtl/l1tol2_req_arb.sv
// N-channel valid/retry request concentrator feeding the L2 pipe, round-robin by default.
// Define L1TOL2_ARB_PRIO_EN for channel-0 strict priority with a STARVE_MAX anti-starvation escape.
module l1tol2_req_arb
    import l2cache_pkg::*;
#(
    parameter int NCH        = L1TOL2_ARB_NCH,
    parameter int DATA_W     = L1TOL2_REQ_W,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCH-1:0]           in_valid,
    output logic [NCH-1:0]           in_retry,
    input  logic [NCH*DATA_W-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_retry,
    output logic [DATA_W-1:0]        out_data,
    output logic [chid_width(NCH)-1:0] out_chid
);

    localparam int CW = chid_width(NCH);

    logic [NCH-1:0]    fifo_empty;
    logic [NCH-1:0]    fifo_full;
    logic [NCH-1:0]    fifo_push;
    logic [NCH-1:0]    grant_vec;
    logic [DATA_W-1:0] head_data [NCH];

    logic              ready;
    logic              grant_any;
    logic [CW-1:0]     grant_idx;
    logic              force0;
    logic              excl0;
    int                cand;

    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic [CW-1:0]     out_chid_reg;
    logic [CW-1:0]     rr_ptr_reg;

    assign ready = !out_valid_reg || !out_retry;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign fifo_push[gi] = in_valid[gi] && !fifo_full[gi];
            assign grant_vec[gi] = ready && grant_any && (grant_idx == CW'(gi));

            l1tol2_arb_fifo #(
                .DATA_W     (DATA_W),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .push      (fifo_push[gi]),
                .push_data (in_data[gi*DATA_W +: DATA_W]),
                .pop       (grant_vec[gi]),
                .head_data (head_data[gi]),
                .empty     (fifo_empty[gi]),
                .full      (fifo_full[gi])
            );
        end
    endgenerate

`ifdef L1TOL2_ARB_PRIO_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0]  starve_cnt_reg;
    logic [NCH-1:0] others_ne_vec;
    logic           others_ne;
    logic           starve_hit;

    always_comb begin
        others_ne_vec    = ~fifo_empty;
        others_ne_vec[0] = 1'b0;
        others_ne        = |others_ne_vec;
        starve_hit       = others_ne && (starve_cnt_reg >= SW'(STARVE_MAX));
    end

    // Counts channel-0 grants that made someone else wait; any other grant resets the run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_reg <= '0;
        end else if (ready && grant_any) begin
            if (grant_idx != '0) begin
                starve_cnt_reg <= '0;
            end else if (others_ne) begin
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
        end
    end
`else
    logic unused_starve_max;
    assign unused_starve_max = (STARVE_MAX != 0);
`endif

    // Search from the rr pointer; in priority mode channel 0 either wins outright or is skipped.
    always_comb begin
        force0    = 1'b0;
        excl0     = 1'b0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
`ifdef L1TOL2_ARB_PRIO_EN
        if (!fifo_empty[0] && !starve_hit) begin
            force0 = 1'b1;
        end else begin
            excl0 = 1'b1;
        end
`endif
        if (force0) begin
            grant_any = 1'b1;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                cand = (int'(rr_ptr_reg) + k) % NCH;
                if (!grant_any && !fifo_empty[cand] && !(excl0 && cand == 0)) begin
                    grant_any = 1'b1;
                    grant_idx = CW'(cand);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_chid_reg  <= '0;
            rr_ptr_reg    <= '0;
        end else if (ready) begin
            out_valid_reg <= grant_any;
            if (grant_any) begin
                out_data_reg <= head_data[grant_idx];
                out_chid_reg <= grant_idx;
                rr_ptr_reg   <= (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign in_retry  = fifo_full;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_chid  = out_chid_reg;

endmodule
